// File: rtl/aemb_arb_pkg.sv
// Shared definitions for the AEMB instruction/data Wishbone arbiter:
// FSM state encoding, master index constants and the default timeout limit.
package aemb_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGntI = 2'd1,
        StGntD = 2'd2
    } arb_state_e;

    // Master identifiers used for the round-robin last-granted record.
    localparam logic MstI = 1'b0;
    localparam logic MstD = 1'b1;

    localparam int unsigned ArbTmoDefault = 15;

endpackage

// File: rtl/aemb_arb_tmo.sv
// Grant timeout counter for the AEMB arbiter. Counts granted cycles that see no
// acknowledge and flags the cycle on which the limit is reached.
module aemb_arb_tmo
    import aemb_arb_pkg::*;
#(
    parameter int unsigned TMO = ArbTmoDefault
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,   // granted, strobe held, no ack this cycle
    output logic hit_o
);

    localparam int unsigned CW = $clog2(TMO + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Limit reached on the TMO-th consecutive cycle without ack.
    assign hit_o = run_i && (cnt_q == CW'(TMO - 1));

    // Next count: clears whenever the grant ends, acks, or times out.
    always_comb begin
        cnt_d = '0;
        if (run_i && !hit_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aemb_wb_arbiter.sv
// Two-master (instruction/data) Wishbone arbiter onto one shared memory port.
// Round-robin on ties, data master wins the first tie after reset.
// Optional grant timeout enabled by defining AEMB_ARB_TIMEOUT_EN.
module aemb_wb_arbiter
    import aemb_arb_pkg::*;
#(
    parameter int unsigned AW  = 16,
    parameter int unsigned TMO = ArbTmoDefault
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    input  logic [AW-1:2] iwb_adr_i,
    input  logic          iwb_stb_i,
    output logic [31:0]   iwb_dat_o,
    output logic          iwb_ack_o,
    input  logic [AW-1:2] dwb_adr_i,
    input  logic          dwb_stb_i,
    input  logic          dwb_wre_i,
    input  logic [3:0]    dwb_sel_i,
    input  logic [31:0]   dwb_dat_i,
    output logic [31:0]   dwb_dat_o,
    output logic          dwb_ack_o,
    output logic [AW-1:2] mem_adr_o,
    output logic          mem_stb_o,
    output logic          mem_wre_o,
    output logic [3:0]    mem_sel_o,
    output logic [31:0]   mem_dat_o,
    input  logic [31:0]   mem_dat_i,
    input  logic          mem_ack_i,
    output logic          arb_err_o
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       gnt_i, gnt_d, gnt_stb, tmo_hit;

    assign gnt_i   = (state_q == StGntI);
    assign gnt_d   = (state_q == StGntD);
    assign gnt_stb = (gnt_i && iwb_stb_i) || (gnt_d && dwb_stb_i);

`ifdef AEMB_ARB_TIMEOUT_EN
    aemb_arb_tmo #(
        .TMO (TMO)
    ) u_tmo (
        .clk_i (sys_clk_i),
        .rst_i (sys_rst_i),
        .run_i (gnt_stb && !mem_ack_i),
        .hit_o (tmo_hit)
    );
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO;
    assign tmo_hit    = 1'b0;
`endif

    assign arb_err_o = tmo_hit;
    assign mem_dat_o = dwb_dat_i;

    // State and last-granted registers with synchronous reset.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q <= StIdle;
            last_q  <= MstI;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next state: arbitrate in idle, release on ack, abort or timeout.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (iwb_stb_i && dwb_stb_i) begin
                    state_d = (last_q == MstI) ? StGntD : StGntI;
                end else if (iwb_stb_i) begin
                    state_d = StGntI;
                end else if (dwb_stb_i) begin
                    state_d = StGntD;
                end
            end
            StGntI: begin
                if (!iwb_stb_i) begin
                    state_d = StIdle;  // abort leaves last-granted untouched
                end else if (mem_ack_i || tmo_hit) begin
                    state_d = StIdle;
                    last_d  = MstI;
                end
            end
            StGntD: begin
                if (!dwb_stb_i) begin
                    state_d = StIdle;
                end else if (mem_ack_i || tmo_hit) begin
                    state_d = StIdle;
                    last_d  = MstD;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Shared-port muxing and per-master acknowledge/read data.
    always_comb begin
        mem_stb_o = gnt_stb && !tmo_hit;
        mem_adr_o = gnt_d ? dwb_adr_i : iwb_adr_i;
        mem_wre_o = gnt_d && dwb_wre_i;
        mem_sel_o = gnt_d ? dwb_sel_i : 4'hF;
        iwb_ack_o = gnt_i && (mem_ack_i || tmo_hit);
        dwb_ack_o = gnt_d && (mem_ack_i || tmo_hit);
        iwb_dat_o = tmo_hit ? 32'h0 : mem_dat_i;
        dwb_dat_o = tmo_hit ? 32'h0 : mem_dat_i;
    end

endmodule

// File: tb/tb_aemb_wb_arbiter.sv
// Self-checking bench for aemb_wb_arbiter: directed scenarios followed by random
// traffic, all compared every cycle against a transaction-level reference model.
module tb_aemb_wb_arbiter;

    localparam int unsigned AW  = 16;
    localparam int unsigned TMO = 15;
`ifdef AEMB_ARB_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:2] iadr, dadr, madr;
    logic          istb, dstb, dwre, mstb, mwre, mack, iack, dack, err;
    logic [3:0]    dsel, msel;
    logic [31:0]   ddat_w, idat, ddat_r, mdat_o, mdat_i;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the port (0 none, 1 I, 2 D), who last completed.
    int owner = 0;
    int last  = 1;
    int tcnt  = 0;

    always #5 clk = ~clk;

    aemb_wb_arbiter #(
        .AW  (AW),
        .TMO (TMO)
    ) dut (
        .sys_clk_i (clk),
        .sys_rst_i (rst),
        .iwb_adr_i (iadr),
        .iwb_stb_i (istb),
        .iwb_dat_o (idat),
        .iwb_ack_o (iack),
        .dwb_adr_i (dadr),
        .dwb_stb_i (dstb),
        .dwb_wre_i (dwre),
        .dwb_sel_i (dsel),
        .dwb_dat_i (ddat_w),
        .dwb_dat_o (ddat_r),
        .dwb_ack_o (dack),
        .mem_adr_o (madr),
        .mem_stb_o (mstb),
        .mem_wre_o (mwre),
        .mem_sel_o (msel),
        .mem_dat_o (mdat_o),
        .mem_dat_i (mdat_i),
        .mem_ack_i (mack),
        .arb_err_o (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare all outputs at the falling edge, then advance the model on the rising edge.
    task automatic step();
        logic        own_stb, hit;
        logic [31:0] exp_dat;
        @(negedge clk);
        own_stb = (owner == 1) ? istb : (owner == 2) ? dstb : 1'b0;
        hit     = TmoEn && own_stb && !mack && (tcnt == TMO - 1);
        exp_dat = hit ? 32'h0 : mdat_i;
        chk("mem_stb", mstb, own_stb && !hit);
        chk("iwb_ack", iack, (owner == 1) && (mack || hit));
        chk("dwb_ack", dack, (owner == 2) && (mack || hit));
        chk("mem_wre", mwre, (owner == 2) && dwre);
        chk("arb_err", err, hit);
        chk("mem_dat_o", mdat_o, ddat_w);
        chk("iwb_dat", idat, exp_dat);
        chk("dwb_dat", ddat_r, exp_dat);
        if (owner != 0) begin
            chk("mem_adr", madr, (owner == 2) ? dadr : iadr);
            chk("mem_sel", msel, (owner == 2) ? dsel : 4'hF);
        end
        @(posedge clk);
        if (rst) begin
            owner = 0;
            last  = 1;
            tcnt  = 0;
        end else if (owner == 0) begin
            tcnt = 0;
            if (istb && dstb) owner = (last == 1) ? 2 : 1;
            else if (istb)    owner = 1;
            else if (dstb)    owner = 2;
        end else if (!own_stb) begin
            owner = 0;
            tcnt  = 0;
        end else if (mack || hit) begin
            last  = owner;
            owner = 0;
            tcnt  = 0;
        end else begin
            tcnt++;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; istb = 0; dstb = 0; dwre = 0; mack = 0;
        iadr = '0; dadr = '0; dsel = 4'h0; ddat_w = '0; mdat_i = 32'h1234_5678;
        step();
        step();
        rst = 1'b0;
        step();

        // Instruction fetch alone, ack one cycle after grant.
        iadr = 14'h0010; istb = 1;
        step();
        mack = 1; mdat_i = 32'hCAFE_0001;
        step();
        chk("i_only_owner_released", owner, 0);
        mack = 0; istb = 0;
        step();

        // Reset so the next tie starts from a fresh last-granted.
        rst = 1; step(); rst = 0;

        // Ties: D first, then alternation.
        iadr = 14'h0100; dadr = 14'h0200; istb = 1; dstb = 1; dsel = 4'hC;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("tie_grant_order", owner, (k % 2 == 0) ? 2 : 1);
            mack = 1;
            step();
            mack = 0;
        end
        istb = 0; dstb = 0;
        step();

        // Data write with a pending fetch held off until the data ack.
        dwre = 1; dsel = 4'h3; ddat_w = 32'hDEAD_BEEF; dstb = 1;
        step();
        istb = 1;
        step();
        step();
        mack = 1;
        step();
        mack = 0; dstb = 0; dwre = 0;
        step();
        mack = 1;
        step();
        mack = 0; istb = 0;
        step();

        // Data abort before ack.
        dstb = 1;
        step();
        dstb = 0;
        step();
        step();

        // Fetch with no ack for a long stretch.
        istb = 1;
        for (int k = 0; k < 40; k++) step();
        istb = 0;
        step();

        // Reset during a data grant; next tie must go to D.
        dstb = 1;
        step();
        rst = 1;
        step();
        rst = 0; istb = 1;
        step();
        chk("tie_after_reset", owner, 2);
        istb = 0; dstb = 0;
        step();

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            rst    = ($urandom_range(0, 99) < 2);
            istb   = ($urandom_range(0, 99) < 70);
            dstb   = ($urandom_range(0, 99) < 60);
            mack   = ($urandom_range(0, 99) < 40);
            dwre   = $urandom_range(0, 1);
            dsel   = 4'($urandom);
            iadr   = 14'($urandom);
            dadr   = 14'($urandom);
            ddat_w = $urandom;
            mdat_i = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aemb_wb_arbiter.md
AEMB_WB_ARBITER -- requirements
Module: aemb_wb_arbiter

Interface
REQ-001 SHALL have parameter AW, default 16, meaning word-address upper bit + 1; address buses are [AW-1:2].
REQ-002 SHALL have parameter TMO, default 15, meaning the timeout limit in cycles (used only with AEMB_ARB_TIMEOUT_EN).
REQ-003 SHALL have the following ports, listed as name  direction  width  meaning:
- sys_clk_i  in  1  single clock, rising edge.
- sys_rst_i  in  1  reset, synchronous and active-high.
- iwb_adr_i  in  AW-2  instruction fetch address.
- iwb_stb_i  in  1  instruction request.
- iwb_dat_o  out  32  instruction read data.
- iwb_ack_o  out  1  instruction acknowledge.
- dwb_adr_i  in  AW-2  data address.
- dwb_stb_i  in  1  data request.
- dwb_wre_i  in  1  data write enable.
- dwb_sel_i  in  4  data byte lanes.
- dwb_dat_i  in  32  data write data.
- dwb_dat_o  out  32  data read data.
- dwb_ack_o  out  1  data acknowledge.
- mem_adr_o  out  AW-2  shared memory address.
- mem_stb_o  out  1  shared memory strobe.
- mem_wre_o  out  1  shared memory write enable.
- mem_sel_o  out  4  shared memory byte lanes.
- mem_dat_o  out  32  shared memory write data.
- mem_dat_i  in  32  shared memory read data.
- mem_ack_i  in  1  shared memory acknowledge.
- arb_err_o  out  1  timeout pulse.

Function
REQ-004 SHALL implement FSM states IDLE, GNT_I, GNT_D; all decisions are registered on the rising edge of sys_clk_i.
REQ-005 IDLE: if only one stb is high, SHALL go to that master's GNT state; if both are high, SHALL grant the master not granted last (round-robin); if neither, SHALL stay in IDLE.
REQ-006 In GNT_x, mem_stb_o SHALL equal stb_x of the granted master, and mem_adr_o SHALL be the granted master's address; outside GNT, mem_stb_o SHALL be 0.
REQ-007 GNT_I SHALL drive mem_wre_o=0, mem_sel_o=4'hF. GNT_D SHALL drive mem_wre_o=dwb_wre_i and mem_sel_o=dwb_sel_i.
REQ-008 mem_dat_o SHALL equal dwb_dat_i at all times.
REQ-009 mem_dat_i SHALL drive both iwb_dat_o and dwb_dat_o at all times.
REQ-010 The granted master's ack SHALL equal mem_ack_i combinationally; the non-granted master's ack SHALL be 0.
REQ-011 The FSM SHALL return to IDLE on the edge where mem_ack_i is high, recording the completed master as last-granted. Minimum occupancy is 2 cycles per transfer (grant edge, then ack edge).
REQ-012 If the granted master drops stb before ack (abort), the FSM SHALL return to IDLE on the next edge and SHALL NOT update last-granted.
REQ-013 A mem_ack_i arriving while in IDLE SHALL be ignored, and no master ack SHALL be asserted.
REQ-014 A new request arriving during GNT SHALL wait and be arbitrated in the next IDLE cycle.

Reset
REQ-015 With sys_rst_i high at an edge, the FSM SHALL enter IDLE, last-granted SHALL become I (so D wins the first tie), the timeout counter SHALL clear, and arb_err_o SHALL be 0.
REQ-016 While the FSM is in IDLE after reset, mem_stb_o, iwb_ack_o, dwb_ack_o and mem_wre_o SHALL be 0.
REQ-017 A reset during GNT SHALL abandon the transfer; mem_stb_o SHALL be 0 from the cycle after the reset edge.

Configuration
REQ-018 With macro AEMB_ARB_TIMEOUT_EN defined, a counter SHALL increment each GNT cycle without ack. On reaching TMO, the block SHALL:
- pulse arb_err_o for 1 cycle,
- assert the granted master's ack for that same cycle, with read data forced to 32'h0,
- drop mem_stb_o,
- return to IDLE.
REQ-019 Without AEMB_ARB_TIMEOUT_EN, there SHALL be no counter, arb_err_o SHALL be tied 0, and GNT SHALL wait indefinitely for ack.

Structure
REQ-020 Package aemb_arb_pkg SHALL hold the FSM state encoding, the I/D master index constants and the default TMO.
REQ-021 The timeout counter SHALL be sub-module aemb_arb_tmo, instantiated only under AEMB_ARB_TIMEOUT_EN; the arbiter FSM and muxes SHALL stay in the top module.

Verification
REQ-022 I-only: iwb_stb_i=1, adr=14'h0010, mem_ack_i one cycle after grant -> mem_adr_o=14'h0010, mem_sel_o=F, mem_wre_o=0, iwb_ack_o=1 for 1 cycle, dwb_ack_o=0.
REQ-023 Tie after reset: both stb high in the same cycle -> D granted first; after D ack, I granted; with both still high, grants alternate D,I,D,I.
REQ-024 D write: dwb_wre_i=1, sel=4'h3, dat=32'hDEADBEEF -> mem_wre_o=1, mem_sel_o=3, mem_dat_o=DEADBEEF; I held off until D ack.
REQ-025 Abort: D granted, dwb_stb_i dropped before ack -> mem_stb_o=0 the same cycle, IDLE next edge, no ack.
REQ-026 Timeout (macro on, TMO=15): I granted, mem_ack_i never asserted -> at 15 cycles, arb_err_o=1 and iwb_ack_o=1 with iwb_dat_o=0 for 1 cycle, then IDLE; with macro off, stb held indefinitely.
REQ-027 Reset mid-GNT: sys_rst_i pulsed during D grant -> mem_stb_o=0 next cycle, and the next tie grants D.
